// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encoding and control FSM states.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: bit 0 of b is folded in at start, then one
// further bit per cycle; done stays high once all WIDTH bits are consumed.
module alu_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   // count==0 means never started; count==LAST means finished and parked
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
         mcand  <= {{WIDTH{1'b0}}, a} << 1;
         mplier <= b >> 1;
         count  <= CW'(1);
      end else if (count != '0 && count != LAST) begin
         if (mplier[0])
            acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
      end
   end

   assign done    = (count == LAST);
   assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with a registered result and back-pressure.
// Define ALU_SEQ_MUL_EN to enable the iterative multiplier for opcode 111.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             zero,
   output logic             illegal
);

   localparam int SW = $clog2(WIDTH);

   state_e           state, state_next;
   logic             accept;
   logic             go_busy;
   logic [WIDTH-1:0] res;
   logic             res_carry;
   logic             res_illegal;
   logic [WIDTH:0]   sum;
   logic [SW-1:0]    shamt;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH:0]   shr_ext;

   assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == HOLD);

   // One guard bit on each side captures the last bit shifted out
   assign shamt   = b[SW-1:0];
   assign shl_ext = {1'b0, a} << shamt;
   assign shr_ext = {a, 1'b0} >> shamt;

`ifdef ALU_SEQ_MUL_EN
   logic                 mul_done;
   logic [2*WIDTH-1:0]   product;

   assign go_busy = (opcode == OP_MUL);

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && go_busy),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );
`else
   assign go_busy = 1'b0;
`endif

   always_comb begin
      res         = '0;
      res_carry   = 1'b0;
      res_illegal = 1'b0;
      sum         = '0;
      case (opcode_e'(opcode))
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_ADD: begin
            sum       = {1'b0, a} + {1'b0, b};
            res       = sum[WIDTH-1:0];
            res_carry = sum[WIDTH];
         end
         OP_SUB: begin
            sum       = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            res       = sum[WIDTH-1:0];
            res_carry = sum[WIDTH];
         end
         OP_SHL: begin
            res       = shl_ext[WIDTH-1:0];
            res_carry = shl_ext[WIDTH];
         end
         OP_SHR: begin
            res       = shr_ext[WIDTH:1];
            res_carry = shr_ext[0];
         end
         OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
            res_illegal = 1'b1;
`endif
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // A drain in HOLD may coincide with a new accept
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = go_busy ? BUSY : HOLD;
`ifdef ALU_SEQ_MUL_EN
         BUSY: if (mul_done) state_next = HOLD;
`endif
         HOLD: begin
            if (out_ready)
               state_next = accept ? (go_busy ? BUSY : HOLD) : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out     <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
         illegal <= 1'b0;
      end else if (accept && !go_busy) begin
         out     <= res;
         carry   <= res_carry;
         zero    <= (res == '0);
         illegal <= res_illegal;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (state == BUSY && mul_done) begin
         out     <= product[WIDTH-1:0];
         carry   <= |product[2*WIDTH-1:WIDTH];
         zero    <= (product[WIDTH-1:0] == '0);
         illegal <= 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases, back-pressure,
// reset abort and randomized operations against an arithmetic reference model.
module tb_alu_seq;

   localparam int WIDTH = 8;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] out;
      logic       carry;
      logic       zero;
      logic       illegal;
   } res_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] opcode;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic       carry;
   logic       zero;
   logic       illegal;

   int tests    = 0;
   int failures = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .carry     (carry),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Reference computed with plain integer arithmetic modulo 256
   function automatic res_t model(input int unsigned op, input int unsigned x, input int unsigned y);
      res_t        m;
      int unsigned r;
      int unsigned c;
      int unsigned ill;
      int unsigned sh;
      int unsigned full;
      r = 0; c = 0; ill = 0; full = 0;
      sh = y % 8;
      case (op)
         0: r = x & y;
         1: r = x | y;
         2: begin r = (x + y) % 256; c = (x + y >= 256) ? 1 : 0; end
         3: begin r = (x + 256 - y) % 256; c = (x >= y) ? 1 : 0; end
         4: r = x ^ y;
         5: begin
            full = x * (1 << sh);
            r = full % 256;
            c = (sh != 0 && (full / 256) % 2 == 1) ? 1 : 0;
         end
         6: begin
            r = x / (1 << sh);
            c = (sh != 0 && (x / (1 << (sh - 1))) % 2 == 1) ? 1 : 0;
         end
         default: begin
            if (MUL_EN) begin
               full = x * y;
               r = full % 256;
               c = (full >= 256) ? 1 : 0;
            end else begin
               ill = 1;
            end
         end
      endcase
      m.out     = r[7:0];
      m.carry   = c[0];
      m.zero    = (r == 0);
      m.illegal = ill[0];
      return m;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      int waited = 0;
      opcode   = op;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      while (!in_ready && waited < 20) begin
         tick();
         waited++;
      end
      checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic waitResult(input int exp_lat, input bit is_mul, input res_t exp, input string tag);
      int lat = 1;
      while (!out_valid && lat < 40) begin
         if (is_mul) checkOutput({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
         tick();
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, "_out"}, {24'd0, out}, {24'd0, exp.out});
      checkOutput({tag, "_carry"}, {31'd0, carry}, {31'd0, exp.carry});
      checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, exp.zero});
      checkOutput({tag, "_illegal"}, {31'd0, illegal}, {31'd0, exp.illegal});
   endtask

   task automatic drain;
      out_ready = 1'b1;
      tick();
      checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0] dop [5];
      logic [7:0] da  [5];
      logic [7:0] db  [5];
      logic [7:0] dout[5];
      logic       dc  [5];
      res_t       exp;
      int         op;
      int         stall;
      logic [7:0] rx;
      logic [7:0] ry;

      dop[0] = 3'b010; da[0] = 8'hF0; db[0] = 8'h20; dout[0] = 8'h10; dc[0] = 1'b1;
      dop[1] = 3'b011; da[1] = 8'h05; db[1] = 8'h05; dout[1] = 8'h00; dc[1] = 1'b1;
      dop[2] = 3'b011; da[2] = 8'h03; db[2] = 8'h05; dout[2] = 8'hFE; dc[2] = 1'b0;
      dop[3] = 3'b101; da[3] = 8'h81; db[3] = 8'h01; dout[3] = 8'h02; dc[3] = 1'b1;
      dop[4] = 3'b110; da[4] = 8'h81; db[4] = 8'h00; dout[4] = 8'h81; dc[4] = 1'b0;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      opcode    = 3'b000;
      a         = 8'h00;
      b         = 8'h00;
      #3;
      checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_out", {24'd0, out}, 32'd0);
      checkOutput("reset_carry", {31'd0, carry}, 32'd0);
      checkOutput("reset_zero", {31'd0, zero}, 32'd0);
      checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(dop[i], da[i], db[i]);
         waitResult(1, 1'b0, model(dop[i], da[i], db[i]), "directed");
         checkOutput("directed_const_out", {24'd0, out}, {24'd0, dout[i]});
         checkOutput("directed_const_carry", {31'd0, carry}, {31'd0, dc[i]});
         drain();
      end

      // Opcode 111: multiplier or illegal single-cycle result
      applyStimulus(3'b111, 8'h10, 8'h11);
      waitResult(MUL_EN ? WIDTH + 1 : 1, MUL_EN, model(7, 8'h10, 8'h11), "op111");
      checkOutput("op111_const_out", {24'd0, out}, MUL_EN ? 32'h10 : 32'h00);
      checkOutput("op111_const_illegal", {31'd0, illegal}, MUL_EN ? 32'd0 : 32'd1);
      drain();

      // Back-pressure then simultaneous drain and accept
      out_ready = 1'b0;
      exp = model(2, 8'h7F, 8'h01);
      applyStimulus(3'b010, 8'h7F, 8'h01);
      waitResult(1, 1'b0, exp, "bp");
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("bp_hold_out", {24'd0, out}, {24'd0, exp.out});
         checkOutput("bp_hold_flags", {29'd0, carry, zero, illegal},
                     {29'd0, exp.carry, exp.zero, exp.illegal});
         checkOutput("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      opcode    = 3'b100;
      a         = 8'h3C;
      b         = 8'h0F;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checkOutput("bp_same_cycle_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      checkOutput("bp_next_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_next_out", {24'd0, out}, {24'd0, model(4, 8'h3C, 8'h0F).out});
      drain();

      // Reset mid-operation must leave no result behind
      if (MUL_EN) begin
         applyStimulus(3'b111, 8'hFF, 8'hFF);
         tick();
         tick();
         tick();
      end else begin
         out_ready = 1'b0;
         applyStimulus(3'b010, 8'hF0, 8'h20);
         tick();
      end
      reset = 1'b1;
      #1;
      checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("abort_out", {24'd0, out}, 32'd0);
      checkOutput("abort_carry", {31'd0, carry}, 32'd0);
      @(negedge clk);
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < WIDTH + 4; i++) begin
         tick();
         checkOutput("abort_no_stale", {31'd0, out_valid}, 32'd0);
      end

      // Randomized operations with random stalls
      for (int i = 0; i < 40; i++) begin
         op    = int'($urandom_range(0, 7));
         rx    = 8'($urandom_range(0, 255));
         ry    = 8'($urandom_range(0, 255));
         stall = int'($urandom_range(0, 2));
         exp   = model(op, rx, ry);
         out_ready = (stall == 0);
         applyStimulus(3'(op), rx, ry);
         waitResult((op == 7 && MUL_EN) ? WIDTH + 1 : 1, (op == 7 && MUL_EN), exp, "rand");
         for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput("rand_stall_out", {24'd0, out}, {24'd0, exp.out});
            checkOutput("rand_stall_valid", {31'd0, out_valid}, 32'd1);
         end
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
